// File: rtl/serial_chunk_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_chunk_adder_pkg
// Shared definitions for the serial chunk adder: FSM state encoding and the
// helper that sizes the chunk index counter.
// -----------------------------------------------------------------------------
package serial_chunk_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter width for N chunks; a single-chunk build still needs one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_chunk_adder_chunk.sv
// -----------------------------------------------------------------------------
// adder_chunk
// Combinational CHUNK-bit adder, the multi-bit generalisation of a 1-bit full
// adder.
// Ports:
//   a, b  : CHUNK-bit addends
//   cin   : carry in
//   sum   : CHUNK-bit sum
//   cout  : carry out of the chunk MSB
// -----------------------------------------------------------------------------
module adder_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic [CHUNK:0] w_full;

    assign w_full      = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    assign {cout, sum} = w_full;

endmodule

// File: rtl/serial_chunk_adder.sv
// -----------------------------------------------------------------------------
// serial_chunk_adder
// Adds (or subtracts) two WIDTH-bit operands CHUNK bits per cycle, LSB chunk
// first, through one shared adder_chunk with a registered carry between chunks.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request; accepted only in IDLE or DONE
//   a, b       : operands, captured on the accepted start edge
//   cin        : add carry-in (ignored when sub=1)
//   sub        : 1 = a - b, 0 = a + b + cin
//   busy       : high while chunks are being processed
//   done       : one-cycle pulse when sum/carry/overflow are valid
//   sum        : result, stable from done until the next accepted start
//   carry      : carry out of the MSB (for sub, 1 = no borrow)
//   overflow   : signed two's-complement overflow
// -----------------------------------------------------------------------------
module serial_chunk_adder
    import serial_chunk_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;      // already inverted for subtraction
    logic [WIDTH-1:0] r_sum;
    logic             r_c;      // carry into the current chunk
    logic             r_carry;
    logic             r_ovf;
    logic [CW-1:0]    r_idx;

    logic             w_accept;
    logic             w_last;
    logic [31:0]      w_base;
    logic [CHUNK-1:0] w_chunk_sum;
    logic             w_chunk_cout;

    assign w_base = 32'(r_idx) * 32'(CHUNK);
    assign w_last = (r_idx == LAST_IDX);

    adder_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a    (r_a[w_base +: CHUNK]),
        .b    (r_b[w_base +: CHUNK]),
        .cin  (r_c),
        .sum  (w_chunk_sum),
        .cout (w_chunk_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_last) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // A start in the done cycle chains straight into a new operation.
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = ST_BUSY;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            // Subtraction is a + ~b + 1, so the +1 enters as the initial carry.
            r_a   <= a;
            r_b   <= sub ? ~b : b;
            r_c   <= sub ? 1'b1 : cin;
            r_idx <= '0;
        end else if (r_state == ST_BUSY) begin
            r_sum[w_base +: CHUNK] <= w_chunk_sum;
            r_c                    <= w_chunk_cout;
            if (w_last) begin
                r_carry <= w_chunk_cout;
                // The top chunk holds the operand and result sign bits.
                r_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                           (w_chunk_sum[CHUNK-1] != r_a[WIDTH-1]);
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign busy     = (r_state == ST_BUSY);
    assign done     = (r_state == ST_DONE);
    assign sum      = r_sum;
    assign carry    = r_carry;
    assign overflow = r_ovf;

endmodule

// File: tb/tb_serial_chunk_adder.sv
module tb_serial_chunk_adder;

    localparam int WIDTH = 32;
    localparam int CHUNK = 8;
    localparam int N     = WIDTH / CHUNK;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;

    logic        start = 1'b0;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        cin   = 1'b0;
    logic        sub   = 1'b0;
    logic        busy, done, carry, overflow;
    logic [31:0] sum;

    logic        start2 = 1'b0;
    logic [31:0] a2     = '0;
    logic [31:0] b2     = '0;
    logic        cin2   = 1'b0;
    logic        sub2   = 1'b0;
    logic        busy2, done2, carry2, overflow2;
    logic [31:0] sum2;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    serial_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy), .done(done), .sum(sum), .carry(carry), .overflow(overflow)
    );

    serial_chunk_adder #(.WIDTH(32), .CHUNK(32)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2), .sub(sub2),
        .busy(busy2), .done(done2), .sum(sum2), .carry(carry2), .overflow(overflow2)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Reference result {overflow, carry, sum} from plain integer arithmetic.
    function automatic logic [33:0] ref_op(input logic [31:0] x, input logic [31:0] y,
                                           input logic ci, input logic s);
        longint ux, uy, ur, sr;
        logic signed [31:0] sx, sy;
        logic c, v;
        ux = longint'(x);
        uy = longint'(y);
        sx = x;
        sy = y;
        if (s) begin
            ur = ux - uy;
            c  = (ux >= uy);
            sr = longint'(sx) - longint'(sy);
        end else begin
            ur = ux + uy + longint'(ci);
            c  = ur[32];
            sr = longint'(sx) + longint'(sy) + longint'(ci);
        end
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return {v, c, ur[31:0]};
    endfunction

    // Transaction-level model: cycles since accept (0 = idle, 1..N busy, N+1 done).
    int          m_cnt   = 0;
    logic [33:0] m_pend  = '0;
    logic [31:0] e_sum   = '0;
    logic        e_carry = 1'b0;
    logic        e_ovf   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt   <= 0;
            e_sum   <= '0;
            e_carry <= 1'b0;
            e_ovf   <= 1'b0;
        end else if ((m_cnt == 0 || m_cnt == N + 1) && start) begin
            m_cnt  <= 1;
            m_pend <= ref_op(a, b, cin, sub);
        end else if (m_cnt >= 1 && m_cnt < N) begin
            m_cnt <= m_cnt + 1;
        end else if (m_cnt == N) begin
            m_cnt <= N + 1;
            {e_ovf, e_carry, e_sum} <= m_pend;
        end else begin
            m_cnt <= 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 64'(busy), 64'(m_cnt >= 1 && m_cnt <= N));
            chk("done", 64'(done), 64'(m_cnt == N + 1));
            chk("carry", 64'(carry), 64'(e_carry));
            chk("overflow", 64'(overflow), 64'(e_ovf));
            if (!(m_cnt >= 1 && m_cnt <= N))
                chk("sum", 64'(sum), 64'(e_sum));
        end
    end

    task automatic run_op(input string nm, input logic [31:0] xa, input logic [31:0] xb,
                          input logic xc, input logic xs,
                          input logic [31:0] es, input logic ec, input logic eo);
        int cyc;
        chk({nm, "_model"}, 64'(ref_op(xa, xb, xc, xs)), 64'({eo, ec, es}));
        @(negedge clk);
        a = xa; b = xb; cin = xc; sub = xs; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs to show the operation uses only captured values.
        start = 1'b0;
        a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
        cyc = 1;
        while (done !== 1'b1 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_latency"}, 64'(cyc), 64'(N + 1));
        chk({nm, "_sum"}, 64'(sum), 64'(es));
        chk({nm, "_carry"}, 64'(carry), 64'(ec));
        chk({nm, "_ovf"}, 64'(overflow), 64'(eo));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sum", 64'(sum), 64'd0);
        chk("rst_carry", 64'(carry), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_sum_n1", 64'(sum2), 64'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        run_op("add_1_0",      32'h00000001, 32'h00000000, 1'b0, 1'b0, 32'h00000001, 1'b0, 1'b0);
        run_op("add_ripple",   32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
        run_op("add_ovf",      32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
        run_op("add_cin",      32'h000000FF, 32'h00000000, 1'b1, 1'b0, 32'h00000100, 1'b0, 1'b0);
        run_op("sub_borrow",   32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
        run_op("sub_ovf",      32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);

        // Abort in the second busy cycle.
        @(negedge clk);
        a = 32'h000000FF; b = 32'h00000001; cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_sum", 64'(sum), 64'd0);
        chk("abort_carry", 64'(carry), 64'd0);
        chk("abort_ovf", 64'(overflow), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_op("after_rst", 32'h00000003, 32'h00000004, 1'b0, 1'b0, 32'h00000007, 1'b0, 1'b0);

        // Single-chunk build.
        @(negedge clk);
        a2 = 32'h12345678; b2 = 32'h11111111; cin2 = 1'b1; sub2 = 1'b0; start2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0; a2 = $urandom; b2 = $urandom;
        chk("n1_busy", 64'(busy2), 64'd1);
        chk("n1_not_done", 64'(done2), 64'd0);
        @(negedge clk);
        chk("n1_done", 64'(done2), 64'd1);
        chk("n1_sum", 64'(sum2), 64'h2345678A);
        chk("n1_carry", 64'(carry2), 64'd0);
        chk("n1_ovf", 64'(overflow2), 64'd0);

        // start held high: requests during busy ignored, done-cycle starts accepted.
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            start = 1'b1; a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);

        // Random traffic with edge-heavy operand choices.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0: a = 32'hFFFFFFFF;
                1: a = 32'h80000000;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0: b = 32'h7FFFFFFF;
                1: b = 32'h00000001;
                default: b = $urandom;
            endcase
            cin = 1'($urandom);
            sub = 1'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation time limit exceeded");
    end

endmodule
